// File: rtl/uart_pkg.sv
// uart_pkg: register map, LSR bit indices and host sequencer state encoding shared with the UART core.
package uart_pkg;
    localparam logic [15:0] ADDR_THR  = 16'h0000;
    localparam logic [15:0] ADDR_FCR  = 16'h0002;
    localparam logic [15:0] ADDR_LCR  = 16'h0003;
    localparam logic [15:0] ADDR_LSR  = 16'h0004;
    localparam logic [15:0] ADDR_DLL  = 16'h0008;
    localparam logic [15:0] ADDR_DLM  = 16'h0009;
    localparam logic [15:0] ADDR_IDLE = 16'hFFFF;
    localparam int DR_BIT   = 0;
    localparam int THRE_BIT = 5;
    localparam int TEMT_BIT = 6;
    localparam int DEF_POLL_LIMIT = 1023;
    typedef enum logic [3:0] {
        IDLE, W_DLL, W_DLM, W_LCR, W_FCR, READY,
        POLL_ADDR, POLL_WAIT, POLL_CHECK, W_THR, GAP
    } seq_state_e;
endpackage

// File: rtl/uart_host_sequencer_if.sv
// uart_host_sequencer_if: core register bus plus the byte valid/ready stream feeding the host sequencer.
interface uart_host_sequencer_if;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    modport master (output address, data_in, tx_ready, input data_out, tx_valid, tx_byte);
    modport slave  (input address, data_in, tx_ready, output data_out, tx_valid, tx_byte);
endinterface

// File: rtl/uart_host_sequencer.sv
// uart_host_sequencer: programs divisor/LCR/FCR once, then polls LSR.THRE and writes each accepted byte to THR.
module uart_host_sequencer
    import uart_pkg::*;
#(
    parameter int POLL_LIMIT = DEF_POLL_LIMIT
) (
    input  logic        m_clk,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic [15:0] cfg_divisor,
    input  logic [7:0]  cfg_lcr,
    input  logic [7:0]  cfg_fcr,
    output logic        cfg_done,
    output logic [7:0]  lsr_last,
    output logic        err_timeout,
    output logic        busy,
    uart_host_sequencer_if.master bus
);
    localparam logic [9:0] LIMIT = 10'(POLL_LIMIT);
    seq_state_e  state, state_n;
    logic [15:0] div_q, div_n, addr_n;
    logic [7:0]  lcr_q, lcr_n, fcr_q, fcr_n, byte_q, byte_n, lsr_n, data_n;
    logic [9:0]  cnt, cnt_n;
    logic        err_n;
    always_comb begin
        state_n = state;
        div_n   = div_q;
        lcr_n   = lcr_q;
        fcr_n   = fcr_q;
        byte_n  = byte_q;
        cnt_n   = cnt;
        lsr_n   = lsr_last;
        err_n   = err_timeout;
        case (state)
            IDLE: if (cfg_start) begin
                state_n = W_DLL;
                div_n   = cfg_divisor;
                lcr_n   = cfg_lcr;
                fcr_n   = cfg_fcr;
            end
            W_DLL:     state_n = W_DLM;
            W_DLM:     state_n = W_LCR;
            W_LCR:     state_n = W_FCR;
            W_FCR:     state_n = READY;
            READY: if (bus.tx_valid) begin
                state_n = POLL_ADDR;
                byte_n  = bus.tx_byte;
                cnt_n   = '0;
            end
            POLL_ADDR: state_n = POLL_WAIT;
            POLL_WAIT: state_n = POLL_CHECK;
            POLL_CHECK: begin
                lsr_n = bus.data_out;
                if (bus.data_out[THRE_BIT]) state_n = W_THR;
                else if (cnt == LIMIT) begin
                    state_n = READY;
                    err_n   = 1'b1;
                end else begin
                    state_n = POLL_ADDR;
                    cnt_n   = cnt + 10'd1;
                end
            end
            W_THR:     state_n = GAP;
            GAP:       state_n = READY;
            default:   state_n = IDLE;
        endcase
        // bus outputs are registered, so they are derived from the state being entered
        addr_n = ADDR_IDLE;
        data_n = 8'h00;
        case (state_n)
            W_DLL:   {addr_n, data_n} = {ADDR_DLL, div_n[7:0]};
            W_DLM:   {addr_n, data_n} = {ADDR_DLM, div_n[15:8]};
            W_LCR:   {addr_n, data_n} = {ADDR_LCR, lcr_n};
            W_FCR:   {addr_n, data_n} = {ADDR_FCR, fcr_n};
            W_THR:   {addr_n, data_n} = {ADDR_THR, byte_n};
            POLL_ADDR, POLL_WAIT, POLL_CHECK: addr_n = ADDR_LSR;
            default: addr_n = ADDR_IDLE;
        endcase
    end
    always_ff @(posedge m_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            div_q        <= '0;
            lcr_q        <= '0;
            fcr_q        <= '0;
            byte_q       <= '0;
            cnt          <= '0;
            lsr_last     <= '0;
            err_timeout  <= 1'b0;
            cfg_done     <= 1'b0;
            busy         <= 1'b0;
            bus.address  <= ADDR_IDLE;
            bus.data_in  <= '0;
            bus.tx_ready <= 1'b0;
        end else begin
            state        <= state_n;
            div_q        <= div_n;
            lcr_q        <= lcr_n;
            fcr_q        <= fcr_n;
            byte_q       <= byte_n;
            cnt          <= cnt_n;
            lsr_last     <= lsr_n;
            err_timeout  <= err_n;
            cfg_done     <= state == W_FCR;
            busy         <= !(state_n == IDLE || state_n == READY);
            bus.address  <= addr_n;
            bus.data_in  <= data_n;
            bus.tx_ready <= state_n == READY;
        end
    end
endmodule

// File: doc/uart_host_sequencer.md
# uart_host_sequencer

Host-side register initiator for the UART core, clocked on the same `m_clk`. It drives the core's address/data_in register bus and reads its data_out bus. After a configuration request it programs the divisor latches, line control and FIFO control registers. It then accepts bytes over a valid/ready handshake, polls the line status register until the transmitter can take data, and writes each byte to the transmit holding register. It is the initiator at the other end of the core's register interface and replaces ad-hoc testbench register pokes.

## Interface
- `ADDR_THR`, 16'h0000, transmit holding register address
- `ADDR_FCR`, 16'h0002, FIFO control register address
- `ADDR_LCR`, 16'h0003, line control register address
- `ADDR_LSR`, 16'h0004, line status register address (read)
- `ADDR_DLL`, 16'h0008, divisor latch LS address
- `ADDR_DLM`, 16'h0009, divisor latch MS address
- `ADDR_IDLE`, 16'hFFFF, address driven when no access is in progress (decodes to nothing)
- `THRE_BIT`, 5, LSR bit meaning "transmitter can accept a byte"
- `POLL_LIMIT`, 1023, maximum LSR polls per byte before timeout
- `m_clk  in  1`  system clock; all logic is on its rising edge
- `reset  in  1`  asynchronous, active-high reset
- `cfg_start  in  1`  one-cycle pulse that requests configuration; sampled only in IDLE
- `cfg_divisor  in  16`  baud divisor; [7:0]→DLL, [15:8]→DLM
- `cfg_lcr  in  8`  LCR value
- `cfg_fcr  in  8`  FCR value
- `cfg_done  out  1`  one-cycle pulse when the FCR write completes
- `tx_valid  in  1`  byte request
- `tx_byte  in  8`  byte to transmit; must stay stable while `tx_valid && !tx_ready`
- `tx_ready  out  1`  high only in READY; a transfer occurs on a cycle with `tx_valid && tx_ready`
- `address  out  16`  register bus address to the core
- `data_in  out  8`  register bus write data to the core
- `data_out  in  8`  register bus read data from the core
- `lsr_last  out  8`  last LSR value sampled
- `err_timeout  out  1`  sticky; set on poll timeout, cleared only by reset
- `busy  out  1`  high in every state except IDLE and READY

## Operation
- FSM states: IDLE, W_DLL, W_DLM, W_LCR, W_FCR, READY, POLL_ADDR, POLL_WAIT, POLL_CHECK, W_THR, GAP.
- Every write state drives its address and data for exactly one cycle. In every other state, `address` is `ADDR_IDLE` and `data_in` is 0, except during polling (see below).
- Configuration sequence: IDLE --`cfg_start`--> W_DLL → W_DLM → W_LCR → W_FCR → READY. `cfg_done` pulses in the cycle after W_FCR.
- `cfg_*` inputs are captured into internal registers on the `cfg_start` cycle. Later changes to the inputs have no effect on the sequence in progress.
- `cfg_start` outside IDLE is ignored.
- Transmit path:
  - READY with `tx_valid` → capture `tx_byte` → POLL_ADDR.
  - POLL_ADDR → POLL_WAIT → POLL_CHECK. `address` is held at `ADDR_LSR` through all three states.
  - In POLL_CHECK, `data_out` is sampled into `lsr_last`.
  - If `lsr_last[THRE_BIT]` is set → W_THR (writes the captured byte) → GAP → READY.
  - If the bit is clear, the poll counter increments and the FSM returns to POLL_ADDR.
- Poll counter: 10 bits, cleared on every accepted byte.
  - Timeout occurs in the POLL_CHECK where the counter equals `POLL_LIMIT` and THRE is clear.
  - On timeout: `err_timeout` is set, the byte is dropped, and the FSM goes to READY.
- The divisor is split exactly as given; there is no arithmetic on it. A divisor of 0 is written as-is.

## Timing
- Reset values: FSM=IDLE; `address`=`ADDR_IDLE`; `data_in`=0; `tx_ready`=0; `cfg_done`=0; `lsr_last`=0; `err_timeout`=0; `busy`=0; poll counter=0; captured registers=0.
- Reset in the middle of any sequence aborts it immediately and returns everything to the reset values. No partial write is completed.
- All outputs are registered.
- Configuration latency: `cfg_start` at cycle 0 → DLL write on the bus in cycle 1, DLM in 2, LCR in 3, FCR in 4. `cfg_done` and `tx_ready` go high in cycle 5.
- LSR read latency is 2 cycles: the core registers `data_out` one edge after it sees the address, and the host samples it one edge after that.
- Per-byte cost with THRE already set: handshake at cycle 0, POLL_ADDR 1, POLL_WAIT 2, POLL_CHECK 3, W_THR 4, GAP 5, `tx_ready` high again at 6. Each failed poll adds 3 cycles.
- After configuration, the FSM only returns to IDLE on reset. READY ignores `cfg_start`.

## Structure
- Shared package `uart_pkg`:
  - register address constants (THR, FCR, LCR, LSR, DLL, DLM, IDLE), shared with the core
  - LSR bit-index constants
  - FSM state encoding
- A single module with no sub-modules; the poll counter is inline.

## Test plan
- Configuration: `cfg_start` with divisor 16'h0145, LCR 8'h03, FCR 8'h07 → bus shows (0008,45), (0009,01), (0003,03), (0002,07) on consecutive cycles 1–4; `cfg_done` pulses at cycle 5; `address`=FFFF otherwise.
- Single byte, model LSR=8'h60: send 8'hA5 → exactly one write (0000,A5) at cycle 4 after the handshake; `lsr_last`=60; `tx_ready` high again at cycle 6.
- Back-pressure: model LSR=8'h00 for 3 polls, then 8'h20 → 4 LSR read windows, then a single THR write; `tx_ready` stays low throughout.
- Timeout with `POLL_LIMIT`=3: LSR stuck at 0 → `err_timeout` set after the 4th poll, no THR write, READY reached; a following byte with LSR=20 is still sent.
- Reset asserted during W_LCR → `address`=FFFF and all outputs at reset values in the same cycle; a later `cfg_start` restarts the sequence from DLL.
- `cfg_start` pulsed while in READY and during a poll → ignored; no extra DLL/DLM writes appear on the bus.
